// File: rtl/ucsbece154b_bp_update_ctrl.sv
// Branch-predictor update controller.
// Resolved control-flow records from execute are queued in a small FIFO and
// drained one per cycle into the BTB and PHT write ports. A pipeline flush
// stops intake, drains whatever is still queued, then pulses the GHR reset.
// Saturating counters track drained updates and mispredictions.
module ucsbece154b_bp_update_ctrl #(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS    = 5,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                               clk,
  input  logic                               reset_ni,

  input  logic                               upd_valid_i,
  output logic                               upd_ready_o,
  input  logic [31:0]                        upd_pc_i,
  input  logic [31:0]                        upd_target_i,
  input  logic [NUM_GHR_BITS-1:0]            upd_phtidx_i,
  input  logic                               upd_is_branch_i,
  input  logic                               upd_is_jump_i,
  input  logic                               upd_taken_i,
  input  logic                               upd_btb_hit_i,
  input  logic                               upd_mispredict_i,

  input  logic                               flush_i,

  output logic                               btb_we_o,
  output logic [$clog2(NUM_BTB_ENTRIES)-1:0] btb_waddr_o,
  output logic [31:0]                        btb_wdata_o,
  output logic [31:0]                        btb_pc_o,

  output logic                               pht_we_o,
  output logic [NUM_GHR_BITS-1:0]            pht_waddr_o,
  output logic                               pht_inc_o,

  output logic                               ghr_reset_o,
  output logic                               busy_o,
  output logic [31:0]                        cnt_updates_o,
  output logic [31:0]                        cnt_mispred_o
);

  localparam int BI = $clog2(NUM_BTB_ENTRIES);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  typedef struct packed {
    logic [31:0]             pc;
    logic [31:0]             target;
    logic [NUM_GHR_BITS-1:0] phtidx;
    logic                    is_branch;
    logic                    is_jump;
    logic                    taken;
    logic                    btb_hit;
    logic                    mispredict;
  } rec_t;

  // Queue storage and bookkeeping
  rec_t          r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;

  // Registered write-port outputs
  logic                    r_btb_we;
  logic [BI-1:0]           r_btb_waddr;
  logic [31:0]             r_btb_wdata;
  logic [31:0]             r_btb_pc;
  logic                    r_pht_we;
  logic [NUM_GHR_BITS-1:0] r_pht_waddr;
  logic                    r_pht_inc;
  logic                    r_ghr_reset;
  logic [31:0]             r_cnt_updates;
  logic [31:0]             r_cnt_mispred;

  rec_t          w_rec_in;
  rec_t          w_head;
  logic          w_push;
  logic          w_pop;
  logic          w_head_cf;
  logic          w_head_btb_wr;
  logic [CW-1:0] w_count_nxt;

  // Intake is closed while flushing and whenever the queue is full, even if
  // a pop happens in the same cycle; ready depends on registered state only.
  assign upd_ready_o = (r_count < DEPTH_C) && (r_state != S_FLUSH);
  assign w_push      = upd_valid_i && upd_ready_o;
  assign w_pop       = ((r_state == S_DRAIN) || (r_state == S_FLUSH)) && (r_count != '0);
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  assign w_rec_in = '{
    pc:         upd_pc_i,
    target:     upd_target_i,
    phtidx:     upd_phtidx_i,
    is_branch:  upd_is_branch_i,
    is_jump:    upd_is_jump_i,
    taken:      upd_taken_i,
    btb_hit:    upd_btb_hit_i,
    mispredict: upd_mispredict_i
  };

  assign w_head        = r_mem[r_rd_ptr];
  assign w_head_cf     = w_head.is_branch || w_head.is_jump;
  // A taken control-flow record needs a BTB write only if the BTB missed or
  // supplied the wrong target.
  assign w_head_btb_wr = w_head_cf && w_head.taken && (!w_head.btb_hit || w_head.mispredict);

  // Queue payload write
  // NOTE: the payload array has no reset; the pointers and count decide what
  // is valid, so clearing the storage itself would buy nothing.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_rec_in;
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_nxt;
    end
  end

  // Next-state selection for the drain/flush sequencer
  // NOTE: w_state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (flush_i)     w_state_nxt = S_FLUSH;
        else if (w_push) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (flush_i)                                 w_state_nxt = S_FLUSH;
        else if ((w_count_nxt == '0) && !w_push)     w_state_nxt = S_IDLE;
      end
      S_FLUSH: begin
        if (r_count == '0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register and GHR reset pulse; the pulse fires on the first edge in
  // FLUSH where nothing is left to pop, so it trails the last update write.
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state     <= S_IDLE;
      r_ghr_reset <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ghr_reset <= (r_state == S_FLUSH) && (r_count == '0);
    end
  end

  // Predictor write ports: enables pulse per pop, address/data hold otherwise
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      r_btb_we    <= 1'b0;
      r_btb_waddr <= '0;
      r_btb_wdata <= '0;
      r_btb_pc    <= '0;
      r_pht_we    <= 1'b0;
      r_pht_waddr <= '0;
      r_pht_inc   <= 1'b0;
    end else begin
      r_btb_we <= w_pop && w_head_btb_wr;
      r_pht_we <= w_pop && w_head.is_branch;
      if (w_pop && w_head_btb_wr) begin
        r_btb_waddr <= w_head.pc[BI+1:2];
        r_btb_wdata <= w_head.target;
        r_btb_pc    <= w_head.pc;
      end
      if (w_pop && w_head.is_branch) begin
        r_pht_waddr <= w_head.phtidx;
        r_pht_inc   <= w_head.taken;
      end
    end
  end

  // Saturating performance counters; records that are neither branch nor
  // jump are dropped without being counted.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      r_cnt_updates <= '0;
      r_cnt_mispred <= '0;
    end else if (w_pop && w_head_cf) begin
      if (r_cnt_updates != '1) r_cnt_updates <= r_cnt_updates + 32'd1;
      if (w_head.mispredict && (r_cnt_mispred != '1)) r_cnt_mispred <= r_cnt_mispred + 32'd1;
    end
  end

  assign btb_we_o      = r_btb_we;
  assign btb_waddr_o   = r_btb_waddr;
  assign btb_wdata_o   = r_btb_wdata;
  assign btb_pc_o      = r_btb_pc;
  assign pht_we_o      = r_pht_we;
  assign pht_waddr_o   = r_pht_waddr;
  assign pht_inc_o     = r_pht_inc;
  assign ghr_reset_o   = r_ghr_reset;
  assign busy_o        = (r_state != S_IDLE);
  assign cnt_updates_o = r_cnt_updates;
  assign cnt_mispred_o = r_cnt_mispred;

endmodule

// File: tb/tb_ucsbece154b_bp_update_ctrl.sv
// Bench for ucsbece154b_bp_update_ctrl: directed records with hand-derived
// expectations. Expected predictor writes and GHR pulses are queued as the
// stimulus is issued; an independent monitor pops and compares them whenever
// the DUT raises a write enable or the GHR reset.
module tb_ucsbece154b_bp_update_ctrl;

  localparam int NB = 32;
  localparam int NG = 5;
  localparam int FD = 4;
  localparam int BI = 5;

  logic          clk = 1'b0;
  logic          reset_ni;
  logic          upd_valid_i;
  logic          upd_ready_o;
  logic [31:0]   upd_pc_i;
  logic [31:0]   upd_target_i;
  logic [NG-1:0] upd_phtidx_i;
  logic          upd_is_branch_i;
  logic          upd_is_jump_i;
  logic          upd_taken_i;
  logic          upd_btb_hit_i;
  logic          upd_mispredict_i;
  logic          flush_i;
  logic          btb_we_o;
  logic [BI-1:0] btb_waddr_o;
  logic [31:0]   btb_wdata_o;
  logic [31:0]   btb_pc_o;
  logic          pht_we_o;
  logic [NG-1:0] pht_waddr_o;
  logic          pht_inc_o;
  logic          ghr_reset_o;
  logic          busy_o;
  logic [31:0]   cnt_updates_o;
  logic [31:0]   cnt_mispred_o;

  always #5 clk = ~clk;

  ucsbece154b_bp_update_ctrl #(
    .NUM_BTB_ENTRIES(NB),
    .NUM_GHR_BITS   (NG),
    .FIFO_DEPTH     (FD)
  ) dut (
    .clk             (clk),
    .reset_ni        (reset_ni),
    .upd_valid_i     (upd_valid_i),
    .upd_ready_o     (upd_ready_o),
    .upd_pc_i        (upd_pc_i),
    .upd_target_i    (upd_target_i),
    .upd_phtidx_i    (upd_phtidx_i),
    .upd_is_branch_i (upd_is_branch_i),
    .upd_is_jump_i   (upd_is_jump_i),
    .upd_taken_i     (upd_taken_i),
    .upd_btb_hit_i   (upd_btb_hit_i),
    .upd_mispredict_i(upd_mispredict_i),
    .flush_i         (flush_i),
    .btb_we_o        (btb_we_o),
    .btb_waddr_o     (btb_waddr_o),
    .btb_wdata_o     (btb_wdata_o),
    .btb_pc_o        (btb_pc_o),
    .pht_we_o        (pht_we_o),
    .pht_waddr_o     (pht_waddr_o),
    .pht_inc_o       (pht_inc_o),
    .ghr_reset_o     (ghr_reset_o),
    .busy_o          (busy_o),
    .cnt_updates_o   (cnt_updates_o),
    .cnt_mispred_o   (cnt_mispred_o)
  );

  typedef struct {
    logic          btb_we;
    logic [BI-1:0] btb_waddr;
    logic [31:0]   btb_wdata;
    logic [31:0]   btb_pc;
    logic          pht_we;
    logic [NG-1:0] pht_waddr;
    logic          pht_inc;
    logic          ghr;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec   = 0;
  int   n_err   = 0;
  int   exp_upd = 0;
  int   exp_mis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: on every output event, pop the next expected item and compare.
  // Address/data fields are checked against the last value written so the
  // hold behaviour is covered too.
  logic [BI-1:0] m_btb_addr;
  logic [31:0]   m_btb_data;
  logic [31:0]   m_btb_pc;
  logic [NG-1:0] m_pht_addr;
  logic          m_pht_inc;
  exp_t          m_e;

  always @(negedge clk) begin
    if (!reset_ni) begin
      m_btb_addr = '0;
      m_btb_data = '0;
      m_btb_pc   = '0;
      m_pht_addr = '0;
      m_pht_inc  = 1'b0;
    end else if (btb_we_o || pht_we_o || ghr_reset_o) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: btb_we=%0b pht_we=%0b ghr=%0b with nothing expected (t=%0t)",
                 btb_we_o, pht_we_o, ghr_reset_o, $time);
      end else begin
        m_e = exp_q.pop_front();
        if (m_e.btb_we) begin
          m_btb_addr = m_e.btb_waddr;
          m_btb_data = m_e.btb_wdata;
          m_btb_pc   = m_e.btb_pc;
        end
        if (m_e.pht_we) begin
          m_pht_addr = m_e.pht_waddr;
          m_pht_inc  = m_e.pht_inc;
        end
        check("sb_btb_we",    32'(btb_we_o),    32'(m_e.btb_we));
        check("sb_pht_we",    32'(pht_we_o),    32'(m_e.pht_we));
        check("sb_ghr",       32'(ghr_reset_o), 32'(m_e.ghr));
        check("sb_btb_waddr", 32'(btb_waddr_o), 32'(m_btb_addr));
        check("sb_btb_wdata", btb_wdata_o,      m_btb_data);
        check("sb_btb_pc",    btb_pc_o,         m_btb_pc);
        check("sb_pht_waddr", 32'(pht_waddr_o), 32'(m_pht_addr));
        check("sb_pht_inc",   32'(pht_inc_o),   32'(m_pht_inc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    upd_valid_i      = 1'b0;
    upd_pc_i         = '0;
    upd_target_i     = '0;
    upd_phtidx_i     = '0;
    upd_is_branch_i  = 1'b0;
    upd_is_jump_i    = 1'b0;
    upd_taken_i      = 1'b0;
    upd_btb_hit_i    = 1'b0;
    upd_mispredict_i = 1'b0;
    flush_i          = 1'b0;
  endtask

  // Drive one record expected to be accepted at the next edge and queue the
  // writes it should produce.
  task automatic drive_rec(input logic [31:0] pc, input logic [31:0] tgt, input logic [NG-1:0] idx,
                           input logic br, input logic jmp, input logic tk,
                           input logic hit, input logic mp);
    exp_t e;
    upd_valid_i      = 1'b1;
    upd_pc_i         = pc;
    upd_target_i     = tgt;
    upd_phtidx_i     = idx;
    upd_is_branch_i  = br;
    upd_is_jump_i    = jmp;
    upd_taken_i      = tk;
    upd_btb_hit_i    = hit;
    upd_mispredict_i = mp;
    e.btb_we    = (br | jmp) & tk & (~hit | mp);
    e.btb_waddr = pc[BI+1:2];
    e.btb_wdata = tgt;
    e.btb_pc    = pc;
    e.pht_we    = br;
    e.pht_waddr = idx;
    e.pht_inc   = tk;
    e.ghr       = 1'b0;
    if (e.btb_we || e.pht_we) exp_q.push_back(e);
    if (br || jmp) begin
      exp_upd++;
      if (mp) exp_mis++;
    end
  endtask

  task automatic expect_ghr();
    exp_t e;
    e.btb_we    = 1'b0;
    e.btb_waddr = '0;
    e.btb_wdata = '0;
    e.btb_pc    = '0;
    e.pht_we    = 1'b0;
    e.pht_waddr = '0;
    e.pht_inc   = 1'b0;
    e.ghr       = 1'b1;
    exp_q.push_back(e);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc_v;
    reset_ni = 1'b0;
    idle_inputs();

    // Reset state
    #12;
    check("rst_btb_we",  32'(btb_we_o),    32'd0);
    check("rst_pht_we",  32'(pht_we_o),    32'd0);
    check("rst_ghr",     32'(ghr_reset_o), 32'd0);
    check("rst_busy",    32'(busy_o),      32'd0);
    check("rst_cnt_upd", cnt_updates_o,    32'd0);
    check("rst_cnt_mis", cnt_mispred_o,    32'd0);
    reset_ni = 1'b1;
    tick();
    check("rst_ready", 32'(upd_ready_o), 32'd1);

    // Single taken branch, latency 1
    drive_rec(32'h40, 32'h80, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    upd_valid_i = 1'b0;
    check("t1_no_write_yet", 32'(pht_we_o), 32'd0);
    check("t1_busy",         32'(busy_o),   32'd1);
    tick();
    check("t1_pht_we",    32'(pht_we_o),    32'd1);
    check("t1_pht_waddr", 32'(pht_waddr_o), 32'd5);
    check("t1_pht_inc",   32'(pht_inc_o),   32'd1);
    check("t1_btb_we",    32'(btb_we_o),    32'd1);
    check("t1_btb_waddr", 32'(btb_waddr_o), 32'd16);
    check("t1_btb_wdata", btb_wdata_o,      32'h80);
    check("t1_cnt_upd",   cnt_updates_o,    32'd1);
    check("t1_busy_done", 32'(busy_o),      32'd0);
    tick();
    check("t1_we_clear", 32'(pht_we_o),    32'd0);
    check("t1_hold",     32'(btb_waddr_o), 32'd16);

    // Burst of 6 back-to-back records
    for (int i = 0; i < 6; i++) begin
      drive_rec(32'h100 + 32'(4 * i), 32'h200 + 32'(8 * i), NG'(i), 1'b1, 1'b0, 1'b1, 1'b0, (i == 3));
      check("burst_ready", 32'(upd_ready_o), 32'd1);
      tick();
      if (i > 0) check("burst_consecutive", 32'(pht_we_o), 32'd1);
    end
    upd_valid_i = 1'b0;
    tick();
    pc_v = 32'h114;
    check("burst_last_we",    32'(btb_we_o),    32'd1);
    check("burst_last_waddr", 32'(btb_waddr_o), 32'(pc_v[BI+1:2]));
    check("burst_busy_drop",  32'(busy_o),      32'd0);
    check("burst_cnt_upd",    cnt_updates_o,    32'(exp_upd));
    check("burst_cnt_mis",    cnt_mispred_o,    32'(exp_mis));
    tick();
    check("burst_we_clear", 32'(pht_we_o), 32'd0);

    // Flush raised alongside the last push while draining
    for (int i = 0; i < 4; i++) begin
      drive_rec(32'h300 + 32'(4 * i), 32'h400 + 32'(4 * i), NG'(10 + i), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      if (i == 3) begin
        flush_i = 1'b1;
        expect_ghr();
      end
      check("fl_ready_pre", 32'(upd_ready_o), 32'd1);
      tick();
    end
    flush_i          = 1'b0;
    upd_pc_i         = 32'hDEAD0000;
    upd_target_i     = 32'hBEEF0000;
    upd_is_branch_i  = 1'b1;
    upd_taken_i      = 1'b1;
    check("fl_ready_low0", 32'(upd_ready_o), 32'd0);
    check("fl_busy",       32'(busy_o),      32'd1);
    check("fl_ghr_early",  32'(ghr_reset_o), 32'd0);
    tick();
    check("fl_ready_low1",  32'(upd_ready_o), 32'd0);
    check("fl_last_write",  32'(pht_we_o),    32'd1);
    check("fl_last_waddr",  32'(pht_waddr_o), 32'd13);
    check("fl_ghr_not_yet", 32'(ghr_reset_o), 32'd0);
    idle_inputs();
    tick();
    check("fl_ghr_pulse",   32'(ghr_reset_o), 32'd1);
    check("fl_no_pht_we",   32'(pht_we_o),    32'd0);
    check("fl_no_btb_we",   32'(btb_we_o),    32'd0);
    check("fl_busy_done",   32'(busy_o),      32'd0);
    check("fl_ready_back",  32'(upd_ready_o), 32'd1);
    tick();
    check("fl_ghr_one_cycle", 32'(ghr_reset_o), 32'd0);
    check("fl_cnt_upd",       cnt_updates_o,    32'(exp_upd));

    // Flush while idle with empty queue
    flush_i = 1'b1;
    expect_ghr();
    tick();
    flush_i = 1'b0;
    check("fi_busy",      32'(busy_o),      32'd1);
    check("fi_ghr_early", 32'(ghr_reset_o), 32'd0);
    tick();
    check("fi_ghr_pulse", 32'(ghr_reset_o), 32'd1);
    check("fi_busy_done", 32'(busy_o),      32'd0);
    tick();
    check("fi_ghr_low",   32'(ghr_reset_o), 32'd0);

    // Not-taken mispredicted branch, hit jump, and a dropped record
    drive_rec(32'h500, 32'h600, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive_rec(32'h504, 32'h700, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    check("nt_pht_we",   32'(pht_we_o),    32'd1);
    check("nt_pht_inc",  32'(pht_inc_o),   32'd0);
    check("nt_pht_addr", 32'(pht_waddr_o), 32'd7);
    check("nt_btb_we",   32'(btb_we_o),    32'd0);
    check("nt_cnt_mis",  cnt_mispred_o,    32'(exp_mis));
    drive_rec(32'h508, 32'h800, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    upd_valid_i = 1'b0;
    check("jmp_btb_we",  32'(btb_we_o),    32'd0);
    check("jmp_pht_we",  32'(pht_we_o),    32'd0);
    check("jmp_cnt_upd", cnt_updates_o,    32'(exp_upd));
    tick();
    idle_inputs();
    check("drop_btb_we",  32'(btb_we_o),  32'd0);
    check("drop_pht_we",  32'(pht_we_o),  32'd0);
    check("drop_cnt_upd", cnt_updates_o,  32'(exp_upd));
    check("drop_cnt_mis", cnt_mispred_o,  32'(exp_mis));
    check("drop_busy",    32'(busy_o),    32'd0);

    // Asynchronous reset in the middle of a drain
    for (int i = 0; i < 3; i++) begin
      drive_rec(32'h900 + 32'(4 * i), 32'hA00 + 32'(4 * i), NG'(20 + i), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
    end
    idle_inputs();
    #5;
    reset_ni = 1'b0;
    #1;
    check("ar_btb_we",  32'(btb_we_o),    32'd0);
    check("ar_pht_we",  32'(pht_we_o),    32'd0);
    check("ar_ghr",     32'(ghr_reset_o), 32'd0);
    check("ar_busy",    32'(busy_o),      32'd0);
    check("ar_cnt_upd", cnt_updates_o,    32'd0);
    check("ar_cnt_mis", cnt_mispred_o,    32'd0);
    exp_q.delete();
    exp_upd = 0;
    exp_mis = 0;
    #2;
    reset_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ar_no_stale_pht", 32'(pht_we_o),    32'd0);
      check("ar_no_stale_btb", 32'(btb_we_o),    32'd0);
      check("ar_ready",        32'(upd_ready_o), 32'd1);
      check("ar_idle",         32'(busy_o),      32'd0);
    end
    check("ar_cnt_upd_after", cnt_updates_o, 32'd0);
    check("ar_cnt_mis_after", cnt_mispred_o, 32'd0);

    tick();
    check("sb_all_consumed", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
